// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter slice.
package dmem_arb_pkg;
  typedef enum logic {ARB = 1'b0, OWN = 1'b1} arb_state_t;

  localparam int DEF_NREQ      = 2;
  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin picker: rotate req so last+1 sits at bit 0, take lowest set bit, rotate back.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  int                  start;
  logic [2*NREQ-1:0]   rot2;
  logic [2*NREQ-1:0]   back2;
  logic [NREQ-1:0]     rot;
  logic [NREQ-1:0]     pick;

  always_comb begin
    start = (last == IW'(NREQ-1)) ? 0 : int'(last) + 1;
    rot2  = {req, req} >> start;
    rot   = rot2[NREQ-1:0];
    pick  = rot & (-rot);
    back2 = {pick, pick} << start;
    gnt   = back2[2*NREQ-1:NREQ];
    idx   = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) idx = IW'(i);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between NREQ requesters: round-robin with bounded lock, registered read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0][AW-1:0]  addr,
  input  logic [NREQ-1:0][DW-1:0]  wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [DW-1:0]            rdata,
  output logic [NREQ-1:0]          rvalid,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_wd,
  input  logic [DW-1:0]            mem_rd
);
  localparam int IW = idx_w(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state, state_n;
  logic [IW-1:0]   last, last_n, owner, owner_n, g, pick_idx;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic [NREQ-1:0] pick_gnt;
  logic            xfer;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    g       = '0;
    xfer    = 1'b0;
    state_n = state;
    last_n  = last;
    owner_n = owner;
    burst_n = burst_cnt;
    if (!reset) begin
      case (state)
        ARB: begin
          if (|req) begin
            gnt    = pick_gnt;
            g      = pick_idx;
            xfer   = 1'b1;
            last_n = pick_idx;
            if (lock[pick_idx] && MAX_BURST > 1) begin
              state_n = OWN;
              owner_n = pick_idx;
              burst_n = BW'(1);
            end
          end
        end
        OWN: begin
          // last still holds owner, so a forced release resumes the search at owner+1
          if (req[owner]) begin
            gnt[owner] = 1'b1;
            g          = owner;
            xfer       = 1'b1;
            burst_n    = burst_cnt + BW'(1);
            if (!lock[owner] || burst_n == BW'(MAX_BURST)) begin
              state_n = ARB;
              burst_n = '0;
            end
          end else begin
            state_n = ARB;
            burst_n = '0;
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

  assign mem_we  = xfer & we[g];
  assign mem_adr = xfer ? addr[g]  : '0;
  assign mem_wd  = xfer ? wdata[g] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      last      <= IW'(NREQ-1);
      owner     <= '0;
      burst_cnt <= '0;
      rdata     <= '0;
      rvalid    <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      owner     <= owner_n;
      burst_cnt <= burst_n;
      if (xfer && !we[g]) begin
        rdata  <= mem_rd;
        rvalid <= gnt;
      end else begin
        rvalid <= '0;
      end
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem: combinational read, write on clk edge) between NREQ requesters, e.g. the mips core and a loader/debug DMA port.
- Round-robin arbitration with optional bounded lock (burst) per requester.
- Registers read data back to the winner one cycle after grant.
- Sits between the requesters and dmem inside top; non-granted requesters stall on !gnt.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive grants a locked owner may hold (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester access request.
- we  in  NREQ  per-requester write enable (valid with req).
- lock  in  NREQ  request to keep ownership next cycle.
- addr  in  NREQ x AW  packed per-requester byte address.
- wdata  in  NREQ x DW  packed per-requester write data.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as issue.
- rdata  out  DW  registered read data, shared by all requesters.
- rvalid  out  NREQ  one-hot; rdata valid for that requester.
- mem_we  out  1  to dmem write enable.
- mem_adr  out  AW  to dmem address.
- mem_wd  out  DW  to dmem write data.
- mem_rd  in  DW  from dmem read data.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - rdata=0, rvalid=0, state=ARB, burst_cnt=0, last=NREQ-1 (requester 0 wins first).
  - While reset is high, gnt=0 and mem_we=0 combinationally.
- Transfers: one per cycle. The granted index g drives mem_adr=addr[g], mem_wd=wdata[g], mem_we=we[g].
  - No grant: mem_we=0, mem_adr=0, mem_wd=0.
- Write: dmem commits on the same edge as the grant; rvalid stays 0 for writes.
- Read: at the edge, rdata<=mem_rd and rvalid[g]<=1 if granted with we=0; otherwise rvalid<=0. Latency is 1 cycle, zero bubbles, so back-to-back reads are allowed.
- State ARB:
  - gnt = round-robin pick of req, searching from last+1 with wrap at NREQ-1 -> 0.
  - On the edge: last<=g.
  - If lock[g] is high and MAX_BURST>1: go to OWN, owner<=g, burst_cnt<=1.
- State OWN:
  - gnt[owner]=req[owner]; other requesters get no grant.
  - On the edge, with req[owner] high: burst_cnt++.
    - If lock[owner] is low, or burst_cnt+1==MAX_BURST: return to ARB.
    - Otherwise stay in OWN.
  - req[owner] low: no transfer, return to ARB immediately (the same cycle's gnt is 0; ARB picks next cycle).
- Forced release after MAX_BURST: the next ARB pick starts at owner+1, so a waiting requester wins. If no other requester is active, the old owner may win again with a fresh burst.
- No requests: gnt=0, state unchanged (ARB), last unchanged.
- gnt is always one-hot or zero; the bench must assert this.
- Reset mid-burst: returns to ARB and clears rvalid; the in-flight read is dropped.
- Address and data pass through unmodified; word alignment is dmem's concern.

Decomposition:
- Shared package dmem_arb_pkg:
  - arb_state_t enum {ARB, OWN}.
  - Default parameter constants.
  - Function for log2-width of the requester index.
- Sub-module rr_pick (NREQ): inputs req and last; outputs one-hot gnt and binary index. Purely combinational rotate-priority-rotate back.
- Top-level owns the state register, burst counter, mux and read register.

Test Plan:
- Reset then single read: reset 2 cycles; req=01, we=0, addr[0]=0x54, mem_rd=0x0000_0007 -> gnt=01, mem_adr=0x54, mem_we=0 same cycle; next cycle rvalid=01, rdata=7.
- Round-robin fairness: req=11 held 4 cycles, lock=0 -> gnt sequence 01,10,01,10; rvalid alternates one cycle later.
- Write pass-through: req=10, we=10, addr[1]=0x60, wdata[1]=0xDEAD_BEEF -> mem_we=1, mem_adr=0x60, mem_wd=0xDEADBEEF; rvalid stays 00.
- Burst cap: MAX_BURST=4, req=11, lock=01 continuously -> gnt 01 for exactly 4 cycles, then 10 for one cycle, then 01 again.
- Owner drop: requester 0 locked in OWN, deasserts req on its 2nd cycle while req[1]=1 -> that cycle gnt=00, mem_we=0; next cycle gnt=10.
- Reset mid-burst: assert reset during OWN with a read in flight -> next cycle rvalid=00, rdata=0; after release, req=11 grants requester 0 first.
